// File: rtl/sa_pkg.sv
// Shared types for the systolic-array feeder: default geometry, lane and
// skew-slot payloads, and the feeder sequencing states.
package sa_pkg;

  localparam int unsigned SA_N      = 4;
  localparam int unsigned SA_DATA_W = 8;
  localparam int unsigned SA_LEN_W  = 4;

  typedef logic [SA_DATA_W-1:0] lane_t;

  typedef struct packed {
    logic  valid;
    lane_t data;
  } skew_slot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and programmable rollover.
// Ports:
//   clk, n_rst      - clock, async active-low reset
//   i_clear         - synchronous clear to 0 (priority over enable)
//   i_count_enable  - advance the count this cycle
//   i_rollover_val  - count wraps to 1 after reaching this value
//   o_count         - current count
module flex_counter #(
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            i_clear,
  input  logic            i_count_enable,
  input  logic [SIZE-1:0] i_rollover_val,
  output logic [SIZE-1:0] o_count
);

  logic [SIZE-1:0] r_count;
  logic [SIZE-1:0] w_count_next;

  // Next count: clear wins, then wrap-or-increment when enabled.
  always_comb begin
    w_count_next = r_count;
    if (i_clear) begin
      w_count_next = '0;
    end else if (i_count_enable) begin
      w_count_next = (r_count == i_rollover_val) ? SIZE'(1) : r_count + SIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sa_skew_feeder.sv
// Feeds one tile of N-lane activation vectors into the systolic array with a
// staircase skew: lane i is delayed i cycles more than lane 0.
// Ports:
//   clk, n_rst          - clock, async active-low reset
//   start, tile_len     - begin a tile of tile_len beats (sampled in IDLE)
//   in_valid, in_data   - upstream vector; lane i = in_data[i*DATA_W +: DATA_W]
//   in_ready            - a beat is accepted when in_valid & in_ready
//   out_valid, out_data - per-lane skewed stream into array row i
//   busy                - feeder is sequencing a tile
//   done                - one-cycle pulse once the tile has fully drained
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int unsigned N      = SA_N,
  parameter int unsigned DATA_W = SA_DATA_W,
  parameter int unsigned LEN_W  = SA_LEN_W
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    tile_len,
  input  logic                in_valid,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                in_ready,
  output logic [N-1:0]        out_valid,
  output logic [N*DATA_W-1:0] out_data,
  output logic                busy,
  output logic                done
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } slot_t;

  feeder_state_t    r_state;
  feeder_state_t    w_state_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_count;
  logic [LEN_W-1:0] w_rollover_val;
  logic             w_accept;
  logic             w_clear;
  logic             w_count_en;
  logic             w_len_load;
  logic             w_last_beat;
  logic             w_drain_end;

  assign w_accept = (r_state == LOAD) && in_valid;

  // The counter holds completed cycles of the current phase, so the phase
  // ends on the cycle that brings it to the target (count == target - 1 now).
  assign w_last_beat = w_accept && (w_count == r_len - LEN_W'(1));
  assign w_drain_end = (r_state == DRAIN) && (w_count == LEN_W'(N - 1));

  assign w_count_en     = w_accept || (r_state == DRAIN);
  assign w_rollover_val = (r_state == DRAIN) ? LEN_W'(N) : r_len;

  // One counter shared by LOAD (beats) and DRAIN (cycles).
  flex_counter #(
    .SIZE (LEN_W)
  ) u_counter (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_clear        (w_clear),
    .i_count_enable (w_count_en),
    .i_rollover_val (w_rollover_val),
    .o_count        (w_count)
  );

  // State and latched tile length.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_len   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_len_load) begin
        r_len <= tile_len;
      end
    end
  end

  // Next-state and phase control.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_len_load   = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (start) begin
          w_len_load   = 1'b1;
          w_state_next = (tile_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (w_last_beat) begin
          w_clear      = 1'b1;
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drain_end) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign in_ready = (r_state == LOAD);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);

  // Lane i: a free-running shift chain of i+1 slots; idle cycles shift in
  // zeroed bubbles so upstream gaps and drain both fall out naturally.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    slot_t r_chain [0:gi];
    slot_t w_head;

    assign w_head.valid = w_accept;
    assign w_head.data  = w_accept ? in_data[gi*DATA_W +: DATA_W] : '0;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        for (int k = 0; k <= gi; k++) begin
          r_chain[k] <= '0;
        end
      end else begin
        r_chain[0] <= w_head;
        for (int k = 1; k <= gi; k++) begin
          r_chain[k] <= r_chain[k-1];
        end
      end
    end

    assign out_valid[gi]                    = r_chain[gi].valid;
    assign out_data[gi*DATA_W +: DATA_W]    = r_chain[gi].data;
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder: stimulus pushes expected lane data with
// the cycle it must appear, expected done cycles and expected control levels;
// a negedge monitor pops and compares.
module tb_sa_skew_feeder;
  import sa_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;

  typedef struct {
    int    cyc;
    lane_t data;
  } lexp_t;

  typedef struct {
    int   cyc;
    logic rdy;
    logic bsy;
    logic zero;
  } cexp_t;

  logic            clk      = 1'b0;
  logic            n_rst    = 1'b0;
  logic            start    = 1'b0;
  logic [LW-1:0]   tile_len = '0;
  logic            in_valid = 1'b0;
  logic [N*DW-1:0] in_data  = '0;
  logic            in_ready;
  logic [N-1:0]    out_valid;
  logic [N*DW-1:0] out_data;
  logic            busy;
  logic            done;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit fin    = 1'b0;

  lexp_t lane_q [N][$];
  int    done_q [$];
  cexp_t ctl_q  [$];

  sa_skew_feeder #(
    .N      (N),
    .DATA_W (DW),
    .LEN_W  (LW)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .tile_len  (tile_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ctl(input logic rdy, input logic bsy, input logic zero);
    cexp_t e;
    e.cyc  = cyc;
    e.rdy  = rdy;
    e.bsy  = bsy;
    e.zero = zero;
    ctl_q.push_back(e);
  endtask

  // Present a beat that will be accepted at the next edge (cyc+1): lane i is
  // due i+1 edges later, i.e. sampled in cycle cyc+1+i.
  task automatic beat(input logic [N*DW-1:0] v, input bit last);
    lexp_t e;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < N; i++) begin
      e.cyc  = cyc + 1 + i;
      e.data = v[i*DW +: DW];
      lane_q[i].push_back(e);
    end
    if (last) done_q.push_back(cyc + 1 + N);
  endtask

  task automatic start_tile(input logic [LW-1:0] len);
    in_valid = 1'b0;
    start    = 1'b1;
    tile_len = len;
    step();
    start = 1'b0;
  endtask

  // Called with cyc = edge of the last accept (first DRAIN cycle already expected).
  task automatic drain_tail();
    in_valid = 1'b1;
    in_data  = 32'hC3C2C1C0;
    for (int k = 1; k < int'(N); k++) begin
      step();
      expect_ctl(1'b0, 1'b1, 1'b0);
    end
    step();
    expect_ctl(1'b0, 1'b1, 1'b1);
    step();
    expect_ctl(1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  initial begin
    // 1: reset held with live inputs, then release into IDLE
    n_rst    = 1'b0;
    start    = 1'b1;
    tile_len = 4'd5;
    in_valid = 1'b1;
    in_data  = 32'hFFEEDDCC;
    repeat (3) begin
      step();
      expect_ctl(1'b0, 1'b0, 1'b1);
    end
    n_rst = 1'b1;
    start = 1'b0;
    step();
    expect_ctl(1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    expect_ctl(1'b0, 1'b0, 1'b1);

    // 2: tile_len=3, back-to-back beats
    start_tile(4'd3);
    expect_ctl(1'b1, 1'b1, 1'b1);
    beat(32'h13121110, 1'b0); step(); expect_ctl(1'b1, 1'b1, 1'b0);
    beat(32'h23222120, 1'b0); step(); expect_ctl(1'b1, 1'b1, 1'b0);
    beat(32'h33323130, 1'b1); step(); expect_ctl(1'b0, 1'b1, 1'b0);
    drain_tail();

    // 3: tile_len=2 with a one-cycle upstream gap
    start_tile(4'd2);
    expect_ctl(1'b1, 1'b1, 1'b1);
    beat(32'hA3A2A1A0, 1'b0); step(); expect_ctl(1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
    step(); expect_ctl(1'b1, 1'b1, 1'b0);
    beat(32'hB3B2B1B0, 1'b1); step(); expect_ctl(1'b0, 1'b1, 1'b0);
    drain_tail();

    // 4: tile_len=0 goes straight to DONE, never ready, no lane data
    in_valid = 1'b1;
    in_data  = 32'h55555555;
    start    = 1'b1;
    tile_len = 4'd0;
    done_q.push_back(cyc + 1);
    step();
    start = 1'b0;
    expect_ctl(1'b0, 1'b1, 1'b1);
    step(); expect_ctl(1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    step(); expect_ctl(1'b0, 1'b0, 1'b1);

    // 5: start with a new length during LOAD is ignored
    start_tile(4'd2);
    expect_ctl(1'b1, 1'b1, 1'b1);
    start    = 1'b1;
    tile_len = 4'd7;
    beat(32'h44434241, 1'b0); step(); expect_ctl(1'b1, 1'b1, 1'b0);
    beat(32'h54535251, 1'b1); step(); expect_ctl(1'b0, 1'b1, 1'b0);
    start = 1'b0;
    drain_tail();

    // 6: reset in the second DRAIN cycle, then a clean tile_len=1 run
    start_tile(4'd2);
    expect_ctl(1'b1, 1'b1, 1'b1);
    beat(32'h64636261, 1'b0); step(); expect_ctl(1'b1, 1'b1, 1'b0);
    beat(32'h74737271, 1'b1); step(); expect_ctl(1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    n_rst = 1'b0;
    for (int i = 0; i < int'(N); i++) lane_q[i].delete();
    done_q.delete();
    expect_ctl(1'b0, 1'b0, 1'b1);
    step(); expect_ctl(1'b0, 1'b0, 1'b1);
    n_rst = 1'b1;
    step(); expect_ctl(1'b0, 1'b0, 1'b1);
    start_tile(4'd1);
    expect_ctl(1'b1, 1'b1, 1'b1);
    beat(32'h84838281, 1'b1); step(); expect_ctl(1'b0, 1'b1, 1'b0);
    drain_tail();

    step();
    step();
    fin = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: fin=%0d required=1", fin);
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    cexp_t ce;
    lexp_t le;
    int    de;

    if (ctl_q.size() > 0 && ctl_q[0].cyc < cyc) begin
      ce = ctl_q.pop_front();
      checks++;
      errors++;
      $display("FAIL ctl_stale: cycle=%0d required cycle=%0d", cyc, ce.cyc);
    end
    if (ctl_q.size() > 0 && ctl_q[0].cyc == cyc) begin
      ce = ctl_q.pop_front();
      checks++;
      if (in_ready !== ce.rdy) begin
        errors++;
        $display("FAIL in_ready @%0d: got %b required %b", cyc, in_ready, ce.rdy);
      end
      checks++;
      if (busy !== ce.bsy) begin
        errors++;
        $display("FAIL busy @%0d: got %b required %b", cyc, busy, ce.bsy);
      end
      if (ce.zero) begin
        checks++;
        if (out_valid !== '0 || out_data !== '0) begin
          errors++;
          $display("FAIL outputs_zero @%0d: out_valid=%b out_data=%h required 0", cyc, out_valid, out_data);
        end
      end
    end

    for (int i = 0; i < int'(N); i++) begin
      if (out_valid[i] === 1'b1) begin
        checks++;
        if (lane_q[i].size() == 0) begin
          errors++;
          $display("FAIL lane%0d_unexpected @%0d: valid=1 data=%h required valid=0", i, cyc, out_data[i*DW +: DW]);
        end else begin
          le = lane_q[i].pop_front();
          if (le.cyc != cyc) begin
            errors++;
            $display("FAIL lane%0d_cycle: got %0d required %0d", i, cyc, le.cyc);
          end
          checks++;
          if (out_data[i*DW +: DW] !== le.data) begin
            errors++;
            $display("FAIL lane%0d_data @%0d: got %h required %h", i, cyc, out_data[i*DW +: DW], le.data);
          end
        end
      end else if (lane_q[i].size() > 0 && lane_q[i][0].cyc <= cyc) begin
        le = lane_q[i].pop_front();
        checks++;
        errors++;
        $display("FAIL lane%0d_missing @%0d: valid=0 required data %h", i, cyc, le.data);
      end
    end

    if (done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected @%0d: got 1 required 0", cyc);
      end else begin
        de = done_q.pop_front();
        if (de != cyc) begin
          errors++;
          $display("FAIL done_cycle: got %0d required %0d", cyc, de);
        end
      end
    end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
      de = done_q.pop_front();
      checks++;
      errors++;
      $display("FAIL done_missing @%0d: got 0 required 1 at %0d", cyc, de);
    end

    if (fin) begin
      for (int i = 0; i < int'(N); i++) begin
        checks++;
        if (lane_q[i].size() != 0) begin
          errors++;
          $display("FAIL lane%0d_leftover: got %0d pending required 0", i, lane_q[i].size());
        end
      end
      checks++;
      if (done_q.size() != 0 || ctl_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: done=%0d ctl=%0d pending required 0", done_q.size(), ctl_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Upstream feeder for the systolic array PE grid. Accepts one N-lane activation vector per beat over valid/ready.
- Emits each lane with a staircase delay: lane i is delayed i cycles more than lane 0, so data enters array row i skewed by i.
- Sequences one tile of tile_len beats plus drain, then pulses done.
- Beat and drain counting reuse the team's flex_counter as the only sub-module.

Parameters:
- N, 4, array dimension (lanes/rows); N >= 1
- DATA_W, 8, bits per lane element
- LEN_W, 4, width of tile_len and of the beat counter

Ports:
- clk  input  1  clock, rising edge
- n_rst  input  1  asynchronous, active-low reset
- start  input  1  begin a tile; sampled only in IDLE
- tile_len  input  LEN_W  beats in tile; latched on accepted start
- in_valid  input  1  upstream vector valid
- in_data  input  N*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
- in_ready  output  1  feeder accepts a beat this cycle
- out_valid  output  N  per-lane valid into array row i
- out_data  output  N*DATA_W  per-lane skewed data, same lane packing
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at end of tile

Behaviour:
- Reset (async, n_rst=0): state IDLE; all skew registers, out_valid, out_data, done, and the latched length clear to 0; in_ready=0; busy=0.
- FSM states:
  - IDLE: on start=1, latch tile_len. If tile_len=0, go to DONE; else go to LOAD, with the beat counter cleared.
  - LOAD: in_ready=1. A beat is accepted on an edge where in_valid & in_ready. On the edge accepting beat number tile_len, go to DRAIN and clear the counter for reuse.
  - DRAIN: in_ready=0. Stay exactly N cycles (counter rollover_val=N), then go to DONE.
  - DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Skew path:
  - Lane i is a chain of i+1 registers, each holding a {valid, data} pair.
  - Every chain shifts every cycle in every state (no stall).
  - The chain head loads {accepted, in_data lane i}; a non-accepted cycle inserts a bubble (valid=0, data=0).
- Latency: a beat accepted at edge E appears on lane i with out_valid[i]=1 during the cycle following edge E+i.
  - Lane 0 has 1-cycle latency; lane N-1 has N-cycle latency.
  - Upstream gaps are preserved per lane.
- Drain timing: the last beat's lane N-1 output is visible in the final DRAIN cycle. done asserts in the next cycle, at which point all out_valid are 0.
- Counter usage: count_enable = accepted beat (LOAD) or 1 (DRAIN); clear on entry to each phase. The phase end is detected when the count equals the target. Counter width is LEN_W; tile_len up to 2^LEN_W-1 is supported.
- start while busy is ignored; tile_len changes after latching are ignored.
- in_valid in IDLE, DRAIN, or DONE: not accepted, no bubble artefacts, in_data ignored.
- N=1: DRAIN lasts 1 cycle; lane 0 is a single register.
- Reset mid-tile: immediate return to IDLE, all in-flight skew data discarded, no done pulse.

Decomposition:
- Shared package sa_pkg:
  - localparam/defaults for N and DATA_W
  - typedef lane_t (logic [DATA_W-1:0])
  - typedef struct skew_slot_t {valid, data}
  - enum feeder_state_t {IDLE, LOAD, DRAIN, DONE}
- One sub-module: flex_counter (SIZE=LEN_W), instantiated once and shared by LOAD and DRAIN via the clear input and a muxed rollover_val.
- Skew chains are generate loops in this block; there is no separate module.

Test Plan:
1. Reset: hold n_rst=0 mid-stream, then release -> all outputs 0, in_ready=0, busy=0 until start.
2. N=4, tile_len=3, in_valid always 1, lanes = {0x13,0x12,0x11,0x10} then +0x10 per beat -> lane i shows 0x1i, 0x2i, 0x3i in consecutive cycles starting i+1 cycles after the first accept. in_ready drops after the 3rd beat; done pulses 4 cycles after the 3rd accept edge +1; busy=1 throughout.
3. Gapped input: tile_len=2, in_valid pattern 1,0,1 -> each lane shows valid,bubble,valid with its own offset; done timing is referenced to the 2nd accept.
4. tile_len=0 with start -> DONE next cycle, done pulse, no out_valid ever asserted, in_ready never 1.
5. start=1 asserted during LOAD with a different tile_len -> ignored; original length completes, exactly one done pulse.
6. n_rst=0 asserted two cycles into DRAIN -> out_valid=0 immediately, no done. A following start with tile_len=1 then runs cleanly with 1-to-4-cycle lane latencies.
